// File: rtl/cb_types_pkg.sv
// Shared types for the out-of-order completion buffer: exception codes,
// the per-entry record and the index-width helper.
package cb_types_pkg;

    typedef enum logic [3:0] {
        EXC_NONE   = 4'd0,
        MAL_L      = 4'd1,
        FAULT_L    = 4'd2,
        MAL_S      = 4'd3,
        FAULT_S    = 4'd4,
        MAL_INSN   = 4'd5,
        FAULT_INSN = 4'd6,
        ILLEGAL    = 4'd7,
        BREAKPOINT = 4'd8,
        ENV_M      = 4'd9,
        RET        = 4'd10
    } cb_exc_t;

    typedef struct packed {
        logic        valid;
        logic        done;
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] data;
        cb_exc_t     exc;
        logic [31:0] badaddr;
    } cb_entry_t;

    function automatic int cb_idx_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ooo_completion_buffer_if.sv
// Dispatch, writeback, hazard and commit signals of the completion buffer.
// master = pipeline side driving the buffer, slave = the buffer itself.
interface ooo_completion_buffer_if
    import cb_types_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int NUM_WB = 4
);
    localparam int IDX_W = cb_idx_w(DEPTH);

    logic                          alloc_en;
    logic [4:0]                    alloc_rd;
    logic                          alloc_wen;
    logic [31:0]                   alloc_pc;
    logic [IDX_W-1:0]              alloc_index;
    logic                          rob_full;
    logic                          rob_empty;
    logic [NUM_WB-1:0]             wb_valid;
    logic [NUM_WB-1:0][IDX_W-1:0]  wb_index;
    logic [NUM_WB-1:0][31:0]       wb_data;
    logic [NUM_WB-1:0][3:0]        wb_exc;
    logic [NUM_WB-1:0][31:0]       wb_badaddr;
    logic                          stall_commit;
    logic                          flush;
    logic                          commit_valid;
    logic                          commit_wen;
    logic [4:0]                    commit_rd;
    logic [31:0]                   commit_data;
    logic                          commit_exc;
    logic [3:0]                    commit_exc_code;
    logic [31:0]                   epc;
    logic [31:0]                   badaddr;

    modport master (
        output alloc_en, alloc_rd, alloc_wen, alloc_pc,
        output wb_valid, wb_index, wb_data, wb_exc, wb_badaddr,
        output stall_commit, flush,
        input  alloc_index, rob_full, rob_empty,
        input  commit_valid, commit_wen, commit_rd, commit_data,
        input  commit_exc, commit_exc_code, epc, badaddr
    );

    modport slave (
        input  alloc_en, alloc_rd, alloc_wen, alloc_pc,
        input  wb_valid, wb_index, wb_data, wb_exc, wb_badaddr,
        input  stall_commit, flush,
        output alloc_index, rob_full, rob_empty,
        output commit_valid, commit_wen, commit_rd, commit_data,
        output commit_exc, commit_exc_code, epc, badaddr
    );

endinterface

// File: rtl/ooo_completion_buffer_wb_arbiter.sv
// Per-entry writeback select: for each buffer entry, picks the lowest-numbered
// port whose index targets it.
module ooo_completion_buffer_wb_arbiter
    import cb_types_pkg::*;
#(
    parameter int  DEPTH  = 16,
    parameter int  NUM_WB = 4,
    localparam int IDX_W  = cb_idx_w(DEPTH)
) (
    input  logic [NUM_WB-1:0]             i_wb_valid,
    input  logic [NUM_WB-1:0][IDX_W-1:0]  i_wb_index,
    input  logic [NUM_WB-1:0][31:0]       i_wb_data,
    input  logic [NUM_WB-1:0][3:0]        i_wb_exc,
    input  logic [NUM_WB-1:0][31:0]       i_wb_badaddr,
    output logic                          o_hit     [DEPTH],
    output logic [31:0]                   o_data    [DEPTH],
    output logic [3:0]                    o_exc     [DEPTH],
    output logic [31:0]                   o_badaddr [DEPTH]
);

    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            o_hit[e]     = 1'b0;
            o_data[e]    = '0;
            o_exc[e]     = '0;
            o_badaddr[e] = '0;
            // Walk from the highest port down so the lowest matching port is the last writer.
            for (int p = NUM_WB - 1; p >= 0; p--) begin
                if (i_wb_valid[p] && (i_wb_index[p] == IDX_W'(e))) begin
                    o_hit[e]     = 1'b1;
                    o_data[e]    = i_wb_data[p];
                    o_exc[e]     = i_wb_exc[p];
                    o_badaddr[e] = i_wb_badaddr[p];
                end
            end
        end
    end

endmodule

// File: rtl/ooo_completion_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order writeback by index,
// in-order retirement or exception report from the head entry.
module ooo_completion_buffer
    import cb_types_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int NUM_WB = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    ooo_completion_buffer_if.slave  bus
);

    localparam int               IDX_W    = cb_idx_w(DEPTH);
    localparam logic [IDX_W:0]   FULL_CNT = (IDX_W + 1)'(DEPTH);

    cb_entry_t        r_ent [DEPTH];
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [IDX_W:0]   r_count;

    logic             w_hit     [DEPTH];
    logic [31:0]      w_data    [DEPTH];
    logic [3:0]       w_exc     [DEPTH];
    logic [31:0]      w_badaddr [DEPTH];

    cb_entry_t        w_h;
    logic             w_full;
    logic             w_alloc;
    logic             w_ready;
    logic             w_commit;

    ooo_completion_buffer_wb_arbiter #(
        .DEPTH  (DEPTH),
        .NUM_WB (NUM_WB)
    ) u_arb (
        .i_wb_valid   (bus.wb_valid),
        .i_wb_index   (bus.wb_index),
        .i_wb_data    (bus.wb_data),
        .i_wb_exc     (bus.wb_exc),
        .i_wb_badaddr (bus.wb_badaddr),
        .o_hit        (w_hit),
        .o_data       (w_data),
        .o_exc        (w_exc),
        .o_badaddr    (w_badaddr)
    );

    assign w_h      = r_ent[r_head];
    assign w_full   = (r_count == FULL_CNT);
    // A full buffer rejects allocation even when the head retires this cycle.
    assign w_alloc  = bus.alloc_en && !w_full && !bus.flush;
    assign w_ready  = w_h.valid && w_h.done && !bus.stall_commit && !bus.flush;
    assign w_commit = w_ready && (w_h.exc == EXC_NONE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int e = 0; e < DEPTH; e++) r_ent[e] <= '0;
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                r_ent[e].valid <= 1'b0;
                r_ent[e].done  <= 1'b0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (w_hit[e] && r_ent[e].valid) begin
                    r_ent[e].done    <= 1'b1;
                    r_ent[e].data    <= w_data[e];
                    r_ent[e].exc     <= cb_exc_t'(w_exc[e]);
                    r_ent[e].badaddr <= w_badaddr[e];
                end
            end
            if (w_commit) begin
                r_ent[r_head].valid <= 1'b0;
                r_head              <= r_head + 1'b1;
            end
            if (w_alloc) begin
                r_ent[r_tail] <= '{valid: 1'b1, done: 1'b0, wen: bus.alloc_wen,
                                   rd: bus.alloc_rd, pc: bus.alloc_pc, data: 32'd0,
                                   exc: EXC_NONE, badaddr: 32'd0};
                r_tail        <= r_tail + 1'b1;
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.alloc_index     = r_tail;
    assign bus.rob_full        = w_full;
    assign bus.rob_empty       = (r_count == '0);
    assign bus.commit_valid    = w_commit;
    assign bus.commit_exc      = w_ready && (w_h.exc != EXC_NONE);
    assign bus.commit_wen      = w_commit && w_h.wen && (w_h.rd != 5'd0);
    assign bus.commit_rd       = w_h.valid ? w_h.rd      : 5'd0;
    assign bus.commit_data     = w_h.valid ? w_h.data    : 32'd0;
    assign bus.commit_exc_code = w_h.valid ? w_h.exc     : 4'd0;
    assign bus.epc             = w_h.valid ? w_h.pc      : 32'd0;
    assign bus.badaddr         = w_h.valid ? w_h.badaddr : 32'd0;

endmodule
